// File: rtl/bus_expander_if.sv
// Handshake bundle for the serial-to-parallel expander: one-bit input stream,
// WIDTH-bit output word with a registered OR summary and a sticky overflow flag.
interface bus_expander_if #(
    parameter int WIDTH = 6
);
    logic             io_in_valid;
    logic             io_in_bit;
    logic             io_in_ready;
    logic             io_msb_first;
    logic             io_out_valid;
    logic             io_out_ready;
    logic [WIDTH-1:0] io_out_bits;
    logic             io_out_any;
    logic             io_overflow;

    // The expander itself
    modport slave (
        input  io_in_valid,
        input  io_in_bit,
        input  io_msb_first,
        input  io_out_ready,
        output io_in_ready,
        output io_out_valid,
        output io_out_bits,
        output io_out_any,
        output io_overflow
    );

    // Producer of serial bits and consumer of words
    modport master (
        output io_in_valid,
        output io_in_bit,
        output io_msb_first,
        output io_out_ready,
        input  io_in_ready,
        input  io_out_valid,
        input  io_out_bits,
        input  io_out_any,
        input  io_overflow
    );
endinterface

// File: rtl/bus_expander.sv
// Serial-to-parallel expander: gathers WIDTH accepted bits into one word and
// presents it on a single-entry output register with valid/ready handshake.
module bus_expander #(
    parameter int WIDTH = 6
) (
    input  logic          clock,
    input  logic          reset,
    bus_expander_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_bits_reg;
    logic             out_any_reg;
    logic             overflow_reg;

    logic             in_xfer;
    logic             slot_free;
    logic             load_out;
    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] hit;
    logic [WIDTH-1:0] assembled;

    assign in_xfer   = bus.io_in_valid & in_ready_reg;
    assign slot_free = ~out_valid_reg | bus.io_out_ready;

    // Drop the incoming bit into the lane selected by arrival index and order.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_place
        localparam logic [CW-1:0] POS_LSB = CW'(gi);
        localparam logic [CW-1:0] POS_MSB = CW'(WIDTH - 1 - gi);
        assign hit[gi]       = bus.io_msb_first ? (count_reg == POS_MSB)
                                                : (count_reg == POS_LSB);
        assign assembled[gi] = hit[gi] ? bus.io_in_bit : shift_reg[gi];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            shift_reg    <= '0;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            shift_reg    <= shift_next;
            in_ready_reg <= (state_next != HOLD);
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        shift_next = shift_reg;
        load_out   = 1'b0;
        load_word  = '0;
        unique case (state_reg)
            IDLE, SHIFT: begin
                if (in_xfer) begin
                    if (count_reg == LAST_IDX) begin
                        count_next = '0;
                        if (slot_free) begin
                            load_out   = 1'b1;
                            load_word  = assembled;
                            shift_next = '0;
                            state_next = IDLE;
                        end else begin
                            // Complete word parks in the shift register until the slot frees.
                            shift_next = assembled;
                            state_next = HOLD;
                        end
                    end else begin
                        shift_next = assembled;
                        count_next = count_reg + 1'b1;
                        state_next = SHIFT;
                    end
                end
            end
            HOLD: begin
                if (slot_free) begin
                    load_out   = 1'b1;
                    load_word  = shift_reg;
                    shift_next = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
                shift_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_bits_reg  <= '0;
            out_any_reg   <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            if (load_out) begin
                out_valid_reg <= 1'b1;
                out_bits_reg  <= load_word;
                out_any_reg   <= |load_word;
            end else if (bus.io_out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (bus.io_in_valid && !in_ready_reg) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign bus.io_in_ready  = in_ready_reg;
    assign bus.io_out_valid = out_valid_reg;
    assign bus.io_out_bits  = out_bits_reg;
    assign bus.io_out_any   = out_any_reg;
    assign bus.io_overflow  = overflow_reg;
endmodule

// File: tb/tb_bus_expander.sv
// Randomized and directed bench for bus_expander against a queue-based model
// of the serial-to-parallel transfer rules.
module tb_bus_expander;
    localparam int W = 6;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    bus_expander_if #(.WIDTH(W)) bus ();

    bus_expander #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Model: accepted bits queue, one pending complete word, one output slot.
    bit     m_bits[$];
    bit     m_pending;
    int     m_pend_word;
    bit     m_valid;
    int     m_word;
    bit     m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pack_word(input bit msb);
        int w = 0;
        for (int k = 0; k < W; k++) begin
            if (m_bits[k]) w = w + (1 << (msb ? (W - 1 - k) : k));
        end
        return w;
    endfunction

    task automatic model_edge();
        bit ready_now = !m_pending;
        bit free_now  = !m_valid || bus.io_out_ready;
        bit emit      = 1'b0;
        int word      = 0;
        if (reset) begin
            m_bits.delete();
            m_pending = 0; m_pend_word = 0;
            m_valid = 0; m_word = 0; m_ovf = 0;
            return;
        end
        if (bus.io_in_valid && !ready_now) m_ovf = 1;
        if (m_pending) begin
            if (free_now) begin
                emit = 1; word = m_pend_word; m_pending = 0;
            end
        end else if (bus.io_in_valid) begin
            m_bits.push_back(bus.io_in_bit);
            if (m_bits.size() == W) begin
                word = pack_word(bus.io_msb_first);
                m_bits.delete();
                if (free_now) emit = 1;
                else begin
                    m_pending = 1; m_pend_word = word;
                end
            end
        end
        if (emit) begin
            m_valid = 1; m_word = word;
        end else if (bus.io_out_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_in_ready"},  32'(bus.io_in_ready),  32'(!m_pending));
        check({tag, "_out_valid"}, 32'(bus.io_out_valid), 32'(m_valid));
        check({tag, "_out_bits"},  32'(bus.io_out_bits),  32'(m_word));
        check({tag, "_out_any"},   32'(bus.io_out_any),   32'(m_word != 0));
        check({tag, "_overflow"},  32'(bus.io_overflow),  32'(m_ovf));
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic step(input bit rst, input bit v, input bit b, input bit ordy, input string tag);
        reset = rst;
        bus.io_in_valid  = v;
        bus.io_in_bit    = b;
        bus.io_out_ready = ordy;
        @(posedge clock);
        model_edge();
        @(negedge clock);
        compare_all(tag);
    endtask

    task automatic send_word(input logic [W-1:0] seq, input bit ordy, input string tag);
        // seq[W-1] is sent first
        for (int k = W - 1; k >= 0; k--) step(0, 1, seq[k], ordy, tag);
    endtask

    initial begin
        bus.io_in_valid  = 0;
        bus.io_in_bit    = 0;
        bus.io_out_ready = 0;
        bus.io_msb_first = 1;
        @(negedge clock);
        step(1, 0, 0, 0, "reset");
        check("reset_ready_const", 32'(bus.io_in_ready), 32'd1);
        check("reset_bits_const",  32'(bus.io_out_bits), 32'd0);

        // Arrival order 1,0,1,1,0,0 with msb first
        send_word(6'b101100, 1, "r029");
        check("r029_valid", 32'(bus.io_out_valid), 32'd1);
        check("r029_bits",  32'(bus.io_out_bits),  32'h2c);
        check("r029_any",   32'(bus.io_out_any),   32'd1);
        step(0, 0, 0, 1, "r029_drain");

        step(1, 0, 0, 1, "reset2");
        bus.io_msb_first = 0;
        send_word(6'b101100, 1, "r030");
        check("r030_bits", 32'(bus.io_out_bits), 32'h0d);

        send_word(6'b000000, 1, "r031");
        check("r031_valid", 32'(bus.io_out_valid), 32'd1);
        check("r031_bits",  32'(bus.io_out_bits),  32'h00);
        check("r031_any",   32'(bus.io_out_any),   32'd0);
        step(0, 0, 0, 1, "r031_drain");

        // Backpressure: two words with consumer stalled, then an extra bit
        step(1, 0, 0, 0, "reset3");
        bus.io_msb_first = 1;
        send_word(6'b110010, 0, "r032a");
        send_word(6'b011011, 0, "r032b");
        check("r032_hold_bits",  32'(bus.io_out_bits), 32'h32);
        check("r032_hold_ready", 32'(bus.io_in_ready), 32'd0);
        check("r032_ovf_before", 32'(bus.io_overflow), 32'd0);
        step(0, 1, 1, 0, "r032_extra");
        check("r032_ovf", 32'(bus.io_overflow), 32'd1);
        step(0, 0, 0, 1, "r032_release");
        check("r032_word2", 32'(bus.io_out_bits), 32'h1b);
        check("r032_ready", 32'(bus.io_in_ready), 32'd1);
        step(0, 0, 0, 1, "r032_drain");

        // Reset mid-word discards the partial bits
        step(1, 0, 0, 1, "reset4");
        for (int k = 0; k < 3; k++) step(0, 1, 1, 1, "r033_partial");
        step(1, 0, 0, 1, "r033_reset");
        check("r033_valid_after_reset", 32'(bus.io_out_valid), 32'd0);
        send_word(6'b000001, 1, "r033");
        check("r033_bits", 32'(bus.io_out_bits), 32'h01);

        // Continuous stream with free consumer: no loss, no overflow
        for (int w = 0; w < 8; w++) begin
            logic [W-1:0] seq = W'($urandom);
            send_word(seq, 1, "r034");
            check("r034_word", 32'(bus.io_out_bits), 32'(seq));
        end
        check("r034_ovf", 32'(bus.io_overflow), 32'd0);

        // Randomized traffic, order fixed between resets
        for (int seg = 0; seg < 12; seg++) begin
            bus.io_msb_first = 1'($urandom);
            step(1, 0, 0, 1'($urandom), "rnd_reset");
            for (int c = 0; c < 250; c++) begin
                step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
                     1'($urandom), ($urandom_range(0, 2) != 0), "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
